led_status_driver: RTL and testbench

LED_STATUS_DRIVER -- requirements
Module: led_status_driver

---
 rtl/led_status_driver.sv | 92 +++++++++
 tb/tb_led_status_driver.sv | 126 ++++++++++++
 2 files changed

// File: rtl/led_status_driver.sv
// led_status_driver: IDLE/RUN/PASS/FAIL status LEDs with tick-based blinking and PWM dimming.
// Define LED_HEARTBEAT_EN to add a one-tick blue heartbeat flash in PASS and FAIL.
module led_status_driver #(
  parameter int TICK_DIV   = 48000,
  parameter int SLOW_TICKS = 500,
  parameter int FAST_TICKS = 100,
  parameter int DUTY       = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_busy,
  input  logic i_step,
  input  logic i_pass,
  input  logic i_fail,
  output logic led_r,
  output logic led_g,
  output logic led_b
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SLOW_TICKS > 1 ? $clog2(SLOW_TICKS) : 1;
  localparam int FW = FAST_TICKS > 1 ? $clog2(FAST_TICKS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] slow_cnt;
  logic [FW-1:0] fast_cnt;
  logic [7:0] pwm_cnt;
  logic slow_ph, fast_ph, act;
  logic tick, slow_wrap, fast_wrap, pwm_on, hb_lit;
  logic lit_r, lit_g, lit_b;
  assign tick      = tick_cnt == TW'(TICK_DIV - 1);
  assign slow_wrap = tick && slow_cnt == SW'(SLOW_TICKS - 1);
  assign fast_wrap = tick && fast_cnt == FW'(FAST_TICKS - 1);
  assign pwm_on    = {1'b0, pwm_cnt} < 9'(DUTY);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      slow_cnt <= '0;
      fast_cnt <= '0;
      pwm_cnt  <= '0;
      slow_ph  <= 1'b0;
      fast_ph  <= 1'b0;
      act      <= 1'b0;
      state    <= IDLE;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 8'd1;
      if (tick) begin
        slow_cnt <= slow_wrap ? '0 : slow_cnt + 1'b1;
        fast_cnt <= fast_wrap ? '0 : fast_cnt + 1'b1;
      end
      slow_ph <= slow_ph ^ slow_wrap;
      fast_ph <= fast_ph ^ fast_wrap;
      act     <= act ^ (state == RUN && i_step);
      state   <= state_nx;
    end
  end
  // fail wins from every state and FAIL only leaves through reset
  always_comb begin
    state_nx = state;
    state_nx = (state == FAIL || i_fail) ? FAIL :
               (state == IDLE && i_busy) ? RUN  :
               (state == RUN && i_pass)  ? PASS : state;
  end
`ifdef LED_HEARTBEAT_EN
  logic hb;
  // hb spans exactly the first tick after slow_ph rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb <= 1'b0;
    else        hb <= (slow_wrap && !slow_ph) ? 1'b1 : tick ? 1'b0 : hb;
  end
  assign hb_lit = hb && (state == PASS || state == FAIL);
`else
  assign hb_lit = 1'b0;
`endif
  always_comb begin
    lit_r = state == FAIL && fast_ph;
    lit_g = (state == RUN && act) || state == PASS;
    lit_b = (state == IDLE && slow_ph) || hb_lit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 1'b1;
      led_g <= 1'b1;
      led_b <= 1'b1;
    end else begin
      led_r <= ~(lit_r && pwm_on);
      led_g <= ~(lit_g && pwm_on);
      led_b <= ~(lit_b && pwm_on);
    end
  end
endmodule

// File: tb/tb_led_status_driver.sv
// tb_led_status_driver: random stimulus vs. a cycle-count based reference model, at DUTY 256 and 64.
module tb_led_status_driver;
  localparam int TD = 4, SLOW = 4, FAST = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_busy = 1'b0, i_step = 1'b0, i_pass = 1'b0, i_fail = 1'b0;
  logic a_r, a_g, a_b, d_r, d_g, d_b;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int n = 0, st = 0, dim_low;
  bit act = 1'b0;
  logic [2:0] exp_a = 3'b111, exp_d = 3'b111;
  always #5 clk = ~clk;
  led_status_driver #(.TICK_DIV(TD), .SLOW_TICKS(SLOW), .FAST_TICKS(FAST), .DUTY(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_busy(i_busy), .i_step(i_step), .i_pass(i_pass), .i_fail(i_fail),
    .led_r(a_r), .led_g(a_g), .led_b(a_b));
  led_status_driver #(.TICK_DIV(TD), .SLOW_TICKS(SLOW), .FAST_TICKS(FAST), .DUTY(64)) u_dim (
    .clk(clk), .rst_n(rst_n), .i_busy(i_busy), .i_step(i_step), .i_pass(i_pass), .i_fail(i_fail),
    .led_r(d_r), .led_g(d_g), .led_b(d_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // st: 0 idle, 1 run, 2 pass, 3 fail; m = clock edges counted since reset release
  function automatic logic [2:0] leds(int s, int m, bit a, int duty);
    int t = m / TD;
    bit on = (m % 256) < duty;
    bit slow = (t / SLOW) % 2 == 1;
    bit fast = (t / FAST) % 2 == 1;
    bit hb = 1'b0;
`ifdef LED_HEARTBEAT_EN
    hb = slow && (t % SLOW == 0) && s >= 2;
`endif
    return ~({s == 3 && fast, (s == 1 && a) || s == 2, (s == 0 && slow) || hb} & {3{on}});
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; st = 0; act = 1'b0; exp_a = 3'b111; exp_d = 3'b111;
    end else begin
      exp_a = leds(st, n, act, 256);
      exp_d = leds(st, n, act, 64);
      if (st == 1 && i_step) act = ~act;
      if (i_fail) st = 3;
      else if (st == 0 && i_busy) st = 1;
      else if (st == 1 && i_pass) st = 2;
      n++;
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("leds_full", {a_r, a_g, a_b}, exp_a);
    check("leds_dim", {d_r, d_g, d_b}, exp_d);
  end
  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      i_busy = 1'b0; i_step = 1'b0; i_pass = 1'b0; i_fail = 1'b0;
      rst_n = 1'b0;
      repeat (10) @(negedge clk);
      check("reset_leds", {a_r, a_g, a_b}, 3'b111);
      rst_n = 1'b1;
      repeat ($urandom_range(20, 60)) begin
        @(negedge clk);
        i_pass = ($urandom % 4) == 0;
        i_step = ($urandom % 4) == 0;
      end
      @(negedge clk);
      i_pass = 1'b0; i_step = 1'b0; i_busy = 1'b1;
      repeat (40) begin
        @(negedge clk);
        i_step = ($urandom % 3) == 0;
      end
      @(negedge clk);
      i_step = 1'b0;
      case (it % 3)
        0: begin
          i_pass = 1'b1;
          @(negedge clk);
          i_pass = 1'b0;
          repeat (2) @(negedge clk);
          dim_low = 0;
          repeat (256) begin
            @(negedge clk);
            if (d_g == 1'b0) dim_low++;
            i_step = ($urandom % 3) == 0;
            i_busy = $urandom % 2;
          end
          check("pwm_duty64", dim_low, 64);
          i_step = 1'b0;
          if (it == 3) begin
            i_fail = 1'b1;
            @(negedge clk);
            i_fail = 1'b0;
            repeat (40) @(negedge clk);
          end
        end
        1: begin
          i_pass = 1'b1; i_fail = 1'b1;
          @(negedge clk);
          i_pass = 1'b0; i_fail = 1'b0;
          repeat (40) @(negedge clk);
          i_pass = 1'b1;
          repeat (10) @(negedge clk);
          i_pass = 1'b0;
          repeat (40) @(negedge clk);
        end
        default: begin
          i_fail = 1'b1;
          @(negedge clk);
          i_fail = 1'b0;
          repeat ($urandom_range(5, 30)) @(negedge clk);
          #2 rst_n = 1'b0;
          #1 check("async_rst", {a_r, a_g, a_b, d_r, d_g, d_b}, 6'h3f);
          @(negedge clk);
          i_busy = 1'b0;
          rst_n = 1'b1;
          repeat (40) @(negedge clk);
        end
      endcase
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
